// File: rtl/grf_sb_if.sv
// ---------------------------------------------------------------------------
// grf_sb_if -- bundle of read, writeback, issue and status signals for the
// scoreboarded general register file.
//
// Signals:
//   rd_addr   [NUM_RD*ADDR_W]  packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data   [NUM_RD*DATA_W]  packed read data, same packing
//   rd_busy   [NUM_RD]         operand k still has an outstanding producer
//   wr_en/wr_addr/wr_data      writeback port
//   wr_pc     [32]             PC of the writing instruction (trace only)
//   iss_en/iss_addr            issue request for a destination register
//   iss_ready                  issue accepted this cycle
//   wb_orphan                  sticky flag: writeback to a register with count 0
//
// Modports: master = pipeline side (drives requests), slave = register file.
// ---------------------------------------------------------------------------
interface grf_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [31:0]              wr_pc;
  logic                     iss_en;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     iss_ready;
  logic                     wb_orphan;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr,
    input  rd_data, rd_busy, iss_ready, wb_orphan
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, wr_pc, iss_en, iss_addr,
    output rd_data, rd_busy, iss_ready, wb_orphan
  );
endinterface

// File: rtl/grf_sb.sv
// ---------------------------------------------------------------------------
// grf_sb -- general register file for the pipelined CPU with NUM_RD
// combinational read ports, write-to-read forwarding and a per-register
// outstanding-producer scoreboard used by the hazard unit.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset (0 = reset); clears registers,
//          scoreboard counts and the orphan flag
//   bus    grf_sb_if.slave: read ports, writeback port, issue port, status
//
// Register 0 reads as zero, is never busy, ignores writes and accepts issues
// without counting them.
//
// Optional: define GRF_SB_TRACE_EN to print one line per accepted write
// ("@pc: $reg <= data"). Without it wr_pc is unused.
// ---------------------------------------------------------------------------
module grf_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2,
  parameter int CNT_W  = 2
) (
  input  logic    clk,
  input  logic    reset,
  grf_sb_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [CNT_W-1:0]  cnt_q  [DEPTH];
  logic [CNT_W-1:0]  cnt_d  [DEPTH];
  logic              wb_orphan_q;
  logic              wb_orphan_d;

  logic [DEPTH-1:0]  wb_hit;
  logic [DEPTH-1:0]  iss_hit;
  logic              iss_ready;
  logic              wr_nz;

  assign wr_nz = bus.wr_en && (bus.wr_addr != '0);

  // A full counter refuses the issue, which is what keeps counts from wrapping.
  assign iss_ready     = (bus.iss_addr == '0) || (cnt_q[bus.iss_addr] != CNT_MAX);
  assign bus.iss_ready = iss_ready;

  // Per-register hit terms; register 0 never counts.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
      if (gi == 0) begin : g_zero
        assign wb_hit[gi]  = 1'b0;
        assign iss_hit[gi] = 1'b0;
      end else begin : g_nz
        assign wb_hit[gi]  = bus.wr_en && (bus.wr_addr == ADDR_W'(gi)) &&
                             (cnt_q[gi] != '0);
        assign iss_hit[gi] = bus.iss_en && iss_ready &&
                             (bus.iss_addr == ADDR_W'(gi));
      end
    end
  endgenerate

  // Issue and writeback in the same cycle cancel out.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (iss_hit[i] && !wb_hit[i]) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (wb_hit[i] && !iss_hit[i]) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // A non-zero writeback landing on a zero count has no matching producer.
  assign wb_orphan_d   = wb_orphan_q | (wr_nz && (cnt_q[bus.wr_addr] == '0));
  assign bus.wb_orphan = wb_orphan_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      wb_orphan_q <= 1'b0;
    end else begin
      if (wr_nz) begin
        regs_q[bus.wr_addr] <= bus.wr_data;
      end
      for (int i = 0; i < DEPTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      wb_orphan_q <= wb_orphan_d;
    end
  end

  // Read ports. Busy reflects the count after this cycle's writeback but
  // before this cycle's issue, so a same-cycle issue never stalls its reader.
  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] ra;
      logic              fwd;
      assign ra  = bus.rd_addr[gi*ADDR_W +: ADDR_W];
      assign fwd = wr_nz && (bus.wr_addr == ra);
      assign bus.rd_data[gi*DATA_W +: DATA_W] =
          fwd          ? bus.wr_data :
          (ra == '0)   ? '0          : regs_q[ra];
      assign bus.rd_busy[gi] =
          (ra != '0) && ((cnt_q[ra] - CNT_W'(wb_hit[ra])) != '0);
    end
  endgenerate

`ifdef GRF_SB_TRACE_EN
  always_ff @(posedge clk) begin
    if (reset && wr_nz) begin
      $display("@%h: $%d <= %h", bus.wr_pc, bus.wr_addr, bus.wr_data);
    end
  end
`else
  logic [31:0] unused_wr_pc;
  assign unused_wr_pc = bus.wr_pc;
`endif

endmodule
